// File: rtl/gpu_command_scheduler.sv
// Routes CPU character writes and clear commands into VRAM, one cell per cycle; 1-cycle request-to-write latency when idle.
// Pending CPU writes wait in a 4-deep FIFO while a clear runs; a write that finds it full or out of range is dropped with cpu_drop.
module gpu_command_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] io_data,
    input  logic [15:0] cpu_write_address,
    input  logic [7:0]  cpu_write_data,
    output logic        vram_we,
    output logic [11:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic [7:0]  font_color,
    output logic [7:0]  bg_color,
    output logic        busy,
    output logic        cpu_drop
);
    typedef enum logic [1:0] {IDLE, CLEAR_SCREEN, CLEAR_LINE} state_t;

    state_t      state, state_nxt;
    logic [15:0] prev_addr;
    logic [7:0]  prev_data, prev_instr;
    logic [19:0] fifo_mem [4];
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  count;
    logic [11:0] clear_end;

    logic [7:0]  instr, operand;
    logic        instr_new, req_new, req_ok;
    logic [4:0]  req_row, line_row;
    logic [6:0]  req_col;
    logic [11:0] req_lin, line_base;
    logic        start_scr, start_line;
    logic        pop, push, bypass, drop;
    logic        we_nxt, busy_nxt;
    logic [11:0] addr_nxt, end_nxt;
    logic [7:0]  wdata_nxt;

    assign instr     = io_data[15:8];
    assign operand   = io_data[7:0];
    assign instr_new = (instr != prev_instr) && (instr != 8'h00);
    // An idle->active transition or any change of address/data counts as a fresh write.
    assign req_new   = !cpu_write_address[15] &&
                       (prev_addr[15] || ({cpu_write_address[14:0], cpu_write_data} != {prev_addr[14:0], prev_data}));
    assign req_row   = cpu_write_address[11:7];
    assign req_col   = cpu_write_address[6:0];
    assign req_ok    = (req_row <= 5'd29) && (req_col <= 7'd79);
    assign req_lin   = {7'd0, req_row} * 12'd80 + {5'd0, req_col};
    assign line_row  = cpu_write_address[12:8];
    assign line_base = {7'd0, line_row} * 12'd80;
    assign start_scr  = (state == IDLE) && instr_new && (instr == 8'h04);
    assign start_line = (state == IDLE) && instr_new && (instr == 8'h05) && (line_row <= 5'd29);

    assign push = req_new && req_ok && !bypass && ((count != 3'd4) || pop);
    assign drop = req_new && !bypass && !push;

    always_comb begin
        state_nxt = state;
        we_nxt    = 1'b0;
        addr_nxt  = vram_addr;
        wdata_nxt = vram_wdata;
        busy_nxt  = busy;
        end_nxt   = clear_end;
        pop       = 1'b0;
        bypass    = 1'b0;
        case (state)
            IDLE: begin
                if (start_scr) begin
                    state_nxt = CLEAR_SCREEN;
                    we_nxt    = 1'b1;
                    addr_nxt  = 12'd0;
                    wdata_nxt = 8'h00;
                    busy_nxt  = 1'b1;
                    end_nxt   = 12'd2399;
                end else if (start_line) begin
                    state_nxt = CLEAR_LINE;
                    we_nxt    = 1'b1;
                    addr_nxt  = line_base;
                    wdata_nxt = 8'h00;
                    busy_nxt  = 1'b1;
                    end_nxt   = line_base + 12'd79;
                end else if (count != 3'd0) begin
                    pop       = 1'b1;
                    we_nxt    = 1'b1;
                    {addr_nxt, wdata_nxt} = fifo_mem[rd_ptr];
                end else if (req_new && req_ok) begin
                    bypass    = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = req_lin;
                    wdata_nxt = cpu_write_data;
                end
            end
            default: begin
                // vram_addr always holds the clear write currently on the bus.
                if (vram_addr == clear_end) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    we_nxt    = 1'b1;
                    addr_nxt  = vram_addr + 12'd1;
                    wdata_nxt = 8'h00;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            vram_we    <= 1'b0;
            vram_addr  <= 12'd0;
            vram_wdata <= 8'h00;
            busy       <= 1'b0;
            cpu_drop   <= 1'b0;
            font_color <= 8'hFF;
            bg_color   <= 8'h00;
            clear_end  <= 12'd0;
            rd_ptr     <= 2'd0;
            wr_ptr     <= 2'd0;
            count      <= 3'd0;
            prev_addr  <= 16'h8000;
            prev_data  <= 8'h00;
            prev_instr <= 8'h00;
        end else begin
            state      <= state_nxt;
            vram_we    <= we_nxt;
            vram_addr  <= addr_nxt;
            vram_wdata <= wdata_nxt;
            busy       <= busy_nxt;
            cpu_drop   <= drop;
            clear_end  <= end_nxt;
            if (instr_new && (instr == 8'h02)) font_color <= operand;
            if (instr_new && (instr == 8'h03)) bg_color   <= operand;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            count      <= count + {2'd0, push} - {2'd0, pop};
            prev_addr  <= cpu_write_address;
            prev_data  <= cpu_write_data;
            prev_instr <= instr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {req_lin, cpu_write_data};
    end
endmodule

// File: tb/tb_gpu_command_scheduler.sv
// Bench for gpu_command_scheduler: queue-based reference model checked every cycle, plus directed literal scenarios.
module tb_gpu_command_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_data;
    logic [15:0] cpu_write_address;
    logic [7:0]  cpu_write_data;
    logic        vram_we;
    logic [11:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  font_color;
    logic [7:0]  bg_color;
    logic        busy;
    logic        cpu_drop;

    gpu_command_scheduler dut (
        .clk(clk), .rst(rst), .io_data(io_data),
        .cpu_write_address(cpu_write_address), .cpu_write_data(cpu_write_data),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .font_color(font_color), .bg_color(bg_color), .busy(busy), .cpu_drop(cpu_drop)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must show after each rising edge.
    logic [19:0] m_q[$];
    int          clear_left, clear_addr;
    logic        m_busy, m_started = 1'b0, addr_known;
    logic        exp_we, exp_drop;
    logic [11:0] exp_addr;
    logic [7:0]  exp_wdata, exp_font, exp_bg;
    logic [15:0] prev_a;
    logic [7:0]  prev_d, prev_i;

    task automatic emit(int a, logic [7:0] d);
        exp_we    = 1'b1;
        exp_addr  = 12'(a);
        exp_wdata = d;
    endtask

    task automatic model_step();
        logic [7:0] ins;
        logic       inew, rnew, rok;
        int         row, col, lrow, base, len;
        logic [19:0] ent;
        m_started = 1'b1;
        if (!rst) begin
            m_q.delete();
            clear_left = 0; m_busy = 1'b0;
            exp_we = 1'b0; exp_addr = 12'd0; exp_wdata = 8'h00; exp_drop = 1'b0;
            exp_font = 8'hFF; exp_bg = 8'h00;
            prev_a = 16'h8000; prev_d = 8'h00; prev_i = 8'h00;
            addr_known = 1'b1;
            return;
        end
        ins  = io_data[15:8];
        inew = (ins != prev_i) && (ins != 8'h00);
        rnew = !cpu_write_address[15] && (prev_a[15] || cpu_write_address[14:0] != prev_a[14:0] || cpu_write_data != prev_d);
        row  = int'(cpu_write_address[11:7]);
        col  = int'(cpu_write_address[6:0]);
        lrow = int'(cpu_write_address[12:8]);
        rok  = (row < 30) && (col < 80);
        exp_drop = 1'b0;
        exp_we   = 1'b0;
        if (inew && ins == 8'h02) exp_font = io_data[7:0];
        if (inew && ins == 8'h03) exp_bg   = io_data[7:0];
        if (m_busy || (inew && (ins == 8'h04 || (ins == 8'h05 && lrow < 30)))) begin
            if (!m_busy) begin
                base = (ins == 8'h04) ? 0 : lrow * 80;
                len  = (ins == 8'h04) ? 2400 : 80;
                emit(base, 8'h00);
                clear_addr = base + 1; clear_left = len - 1; m_busy = 1'b1;
            end else if (clear_left > 0) begin
                emit(clear_addr, 8'h00);
                clear_addr++; clear_left--;
            end else begin
                m_busy = 1'b0;
            end
            if (rnew) begin
                if (!rok || m_q.size() >= 4) exp_drop = 1'b1;
                else m_q.push_back({12'(row * 80 + col), cpu_write_data});
            end
        end else if (m_q.size() > 0) begin
            ent = m_q.pop_front();
            emit(int'(ent[19:8]), ent[7:0]);
            if (rnew) begin
                if (!rok) exp_drop = 1'b1;
                else m_q.push_back({12'(row * 80 + col), cpu_write_data});
            end
        end else if (rnew) begin
            if (rok) emit(row * 80 + col, cpu_write_data);
            else exp_drop = 1'b1;
        end
        addr_known = exp_we;
        prev_a = cpu_write_address; prev_d = cpu_write_data; prev_i = ins;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (m_started) begin
            chk("vram_we", vram_we, exp_we);
            chk("busy", busy, m_busy);
            chk("cpu_drop", cpu_drop, exp_drop);
            chk("font_color", font_color, exp_font);
            chk("bg_color", bg_color, exp_bg);
            if (addr_known) begin
                chk("vram_addr", vram_addr, exp_addr);
                chk("vram_wdata", vram_wdata, exp_wdata);
            end
        end
    end

    // Passive capture for the directed scenarios.
    logic [19:0] mon_q[$];
    int          mon_drops = 0;
    always @(negedge clk) begin
        if (vram_we === 1'b1) mon_q.push_back({vram_addr, vram_wdata});
        if (cpu_drop === 1'b1) mon_drops++;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] mk_addr(int row, int col);
        return {1'b0, 3'b000, 5'(row), 7'(col)};
    endfunction

    task automatic wait_idle(string nm, int bound, output int n);
        n = 0;
        while (busy === 1'b1 && n < bound) begin
            tick(1);
            n++;
        end
        chk(nm, busy, 1'b0);
    endtask

    initial begin
        int n, bad, idx;
        logic [19:0] got[$];
        logic [7:0]  ins;
        rst = 1'b0; io_data = 16'h0000; cpu_write_address = 16'h8000; cpu_write_data = 8'h00;
        tick(2);
        chk("rst_font", font_color, 8'hFF);
        chk("rst_bg", bg_color, 8'h00);
        chk("rst_we", vram_we, 1'b0);
        chk("rst_addr", vram_addr, 12'd0);
        rst = 1'b1;
        tick(2);

        // Single write, one-cycle latency, no re-trigger while held.
        cpu_write_address = mk_addr(2, 5); cpu_write_data = 8'h41;
        tick(1);
        chk("wr_we", vram_we, 1'b1);
        chk("wr_addr", vram_addr, 12'd165);
        chk("wr_data", vram_wdata, 8'h41);
        tick(1);
        chk("wr_held_no_retrigger", vram_we, 1'b0);
        cpu_write_address = 16'h8000;
        tick(2);

        // Full-screen clear.
        mon_q.delete();
        io_data = 16'h0400;
        tick(1);
        chk("clr_scr_busy_on", busy, 1'b1);
        wait_idle("clr_scr_done", 3000, n);
        chk("clr_scr_busy_cycles", n, 2400);
        bad = 0;
        foreach (mon_q[i]) if (mon_q[i] != {12'(i), 8'h00}) bad++;
        chk("clr_scr_count", mon_q.size(), 2400);
        chk("clr_scr_bad_cells", bad, 0);
        io_data = 16'h0000;
        tick(2);

        // Line clear of row 5, then an out-of-range row.
        mon_q.delete();
        cpu_write_address = 16'h8500; io_data = 16'h0500;
        tick(1);
        wait_idle("clr_line_done", 200, n);
        chk("clr_line_busy_cycles", n, 80);
        bad = 0;
        foreach (mon_q[i]) if (mon_q[i] != {12'(400 + i), 8'h00}) bad++;
        chk("clr_line_count", mon_q.size(), 80);
        chk("clr_line_bad_cells", bad, 0);
        io_data = 16'h0000;
        tick(2);
        mon_q.delete();
        cpu_write_address = 16'h9F00; io_data = 16'h0500;
        tick(5);
        chk("clr_row31_writes", mon_q.size(), 0);
        chk("clr_row31_busy", busy, 1'b0);
        io_data = 16'h0000; cpu_write_address = 16'h8000;
        tick(2);

        // Five writes during a clear: four survive in order, one dropped.
        mon_q.delete(); mon_drops = 0;
        io_data = 16'h0400;
        tick(1);
        io_data = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            cpu_write_address = mk_addr(1, i); cpu_write_data = 8'(8'h30 + i);
            tick(1);
        end
        cpu_write_address = 16'h8000;
        wait_idle("fifo_clr_done", 3000, n);
        tick(6);
        got.delete();
        foreach (mon_q[i]) if (mon_q[i][7:0] != 8'h00) got.push_back(mon_q[i]);
        chk("fifo_survivors", got.size(), 4);
        chk("fifo_drops", mon_drops, 1);
        for (int i = 0; i < 4; i++)
            chk("fifo_order", (i < got.size()) ? got[i] : 20'h0, {12'(80 + i), 8'(8'h30 + i)});

        // Colour loads; a held opcode with new operand must not reload.
        io_data = 16'h021C; tick(1);
        chk("font_load", font_color, 8'h1C);
        io_data = 16'h03E0; tick(1);
        chk("bg_load", bg_color, 8'hE0);
        io_data = 16'h0377; tick(2);
        chk("bg_held", bg_color, 8'hE0);
        io_data = 16'h0000; tick(1);

        // Reset at the 100th clear cycle with FIFO entries pending.
        io_data = 16'h0400; tick(1);
        io_data = 16'h0000;
        cpu_write_address = mk_addr(3, 1); cpu_write_data = 8'h55; tick(1);
        cpu_write_address = mk_addr(3, 2); tick(1);
        cpu_write_address = 16'h8000; tick(1);
        tick(96);
        rst = 1'b0;
        tick(1);
        chk("rstmid_we", vram_we, 1'b0);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_font", font_color, 8'hFF);
        rst = 1'b1;
        mon_q.delete();
        tick(4);
        chk("rstmid_fifo_empty", mon_q.size(), 0);

        // Randomized traffic checked by the model each cycle.
        for (int c = 0; c < 6000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 30) cpu_write_address = 16'h8000 | 16'($urandom_range(0, 16'h7FFF));
            else if (r < 70) begin
                cpu_write_address = {1'b0, 3'($urandom), 5'($urandom_range(0, 31)),
                                     7'(($urandom_range(0, 9) == 0) ? $urandom_range(80, 127) : $urandom_range(0, 79))};
                cpu_write_data = 8'($urandom);
            end
            r = $urandom_range(0, 99);
            if (r < 8) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: ins = 8'h02;
                    3, 4:    ins = 8'h03;
                    5:       ins = 8'h05;
                    6:       ins = ($urandom_range(0, 3) == 0) ? 8'h04 : 8'h00;
                    7:       ins = 8'($urandom);
                    default: ins = 8'h00;
                endcase
                io_data = {ins, 8'($urandom)};
            end
            rst = ($urandom_range(0, 599) != 0);
            tick(1);
        end
        rst = 1'b1;
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
